rr_arb_mux: RTL

- Parametrised N-channel, W-bit registered round-robin arbitrating mux with valid/ready handshakes on every input and on the output.
- Successor to the fixed 4:1 combinational muxes: select is generated internally by fair arbitration, not driven externally.
- Sits between multiple producer streams and one shared consumer, such as a shared display or sound-sample sink.
- One output register stage.

---
 rtl/rr_arb_mux.sv | 113 +++++++++++
 1 files changed

// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbitrating mux with valid/ready on every port and one registered output stage.
// Define RR_ARB_MUX_LAST_LOCK_EN to hold the grant on a channel until it sends a beat with in_last set.
module rr_arb_mux #(
    parameter int N_CH = 4,
    parameter int W = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    input  logic [N_CH*W-1:0] in_data,
    input  logic [N_CH-1:0]   in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_sel
);

    // Handshake: a beat moves on channel i when in_valid[i] && in_ready[i], and leaves on
    // out_valid && out_ready; in_ready never depends on in_data and is zero while rst is high.

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_next;
    logic [N_CH-1:0]  req;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             load_en;
    logic             xfer;
    logic [W-1:0]     ch_data [N_CH];

    assign load_en = !out_valid || out_ready;
    assign xfer    = !rst && load_en && grant_vld;

`ifdef RR_ARB_MUX_LAST_LOCK_EN
    logic locked;

    // While locked, ptr holds the owning channel, so only that channel may request.
    assign req = locked ? (in_valid & (N_CH'(1) << ptr)) : in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
        end else if (xfer) begin
            locked <= !in_last[grant_idx];
        end
    end
`else
    logic unused_last;

    assign unused_last = ^in_last;
    assign req = in_valid;
`endif

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ch_data[i] = in_data[i*W +: W];
        end
    end

    // Search ptr, ptr+1, ... with wrap-around; first requester wins.
    always_comb begin : grant_search
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(k);
            if (sum >= (SEL_W+1)'(N_CH)) begin
                sum = sum - (SEL_W+1)'(N_CH);
            end
            cand = sum[SEL_W-1:0];
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign ptr_next = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (grant_vld) begin
                out_valid <= 1'b1;
                out_data  <= ch_data[grant_idx];
                out_sel   <= grant_idx;
`ifdef RR_ARB_MUX_LAST_LOCK_EN
                ptr       <= in_last[grant_idx] ? ptr_next : grant_idx;
`else
                ptr       <= ptr_next;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
